movable_block: RTL and testbench

MOVABLE_BLOCK -- requirements
Module: movable_block

---
 rtl/movable_block_pkg.sv | 28 ++
 rtl/movable_block_if.sv | 35 +++
 rtl/movable_block_btn_repeat.sv | 84 ++++++++
 rtl/movable_block.sv | 125 ++++++++++++
 tb/tb_movable_block.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/movable_block_pkg.sv
// Shared encodings for the movable block: button codes, repeat FSM states
// and helpers for the legal range of the block's top-left corner.
package movable_block_pkg;

    localparam logic [3:0] BTN_NONE = 4'b0000;
    localparam logic [3:0] BTN_U    = 4'b1000;
    localparam logic [3:0] BTN_D    = 4'b0100;
    localparam logic [3:0] BTN_R    = 4'b0010;
    localparam logic [3:0] BTN_L    = 4'b0001;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        REPEAT
    } rep_state_t;

    localparam int EDGE_MIN = 0;

    // Largest coordinate that keeps the whole object on screen.
    function automatic int edge_max(input int res, input int obj);
        return res - obj;
    endfunction

    function automatic logic is_one_hot(input logic [3:0] b);
        return (b == BTN_U) || (b == BTN_D) || (b == BTN_R) || (b == BTN_L);
    endfunction

endpackage

// File: rtl/movable_block_if.sv
// Bundle of everything the movable block exchanges with the rest of the game:
// buttons, player description and block position/collision outputs.
interface movable_block_if #(
    parameter int COORD_W = 11
);
    logic [3:0]         btns;
    logic               visible;
    logic               passable;
    logic [3:0]         rect_color;
    logic [3:0]         player_color;
    logic [COORD_W-1:0] player_hPos;
    logic [COORD_W-1:0] player_vPos;
    logic [COORD_W-1:0] hStart;
    logic [COORD_W-1:0] vStart;
    logic [COORD_W-1:0] hPos;
    logic [COORD_W-1:0] vPos;
    logic               upBlock;
    logic               downBlock;
    logic               leftBlock;
    logic               rightBlock;
    logic               hit;
    logic               moving;

    modport master (
        output btns, visible, passable, rect_color, player_color,
               player_hPos, player_vPos, hStart, vStart,
        input  hPos, vPos, upBlock, downBlock, leftBlock, rightBlock, hit, moving
    );

    modport slave (
        input  btns, visible, passable, rect_color, player_color,
               player_hPos, player_vPos, hStart, vStart,
        output hPos, vPos, upBlock, downBlock, leftBlock, rightBlock, hit, moving
    );
endinterface

// File: rtl/movable_block_btn_repeat.sv
// Button auto-repeat: one move on press, another after REPEAT_DLY cycles,
// then one every REPEAT_RATE cycles while the same button stays held.
module btn_repeat #(
    parameter int REPEAT_DLY  = 20,
    parameter int REPEAT_RATE = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btns,
    output logic       move,
    output logic [3:0] dir,
    output logic       moving
);
    import movable_block_pkg::*;

    localparam int CNT_MAX = (REPEAT_DLY > REPEAT_RATE) ? REPEAT_DLY : REPEAT_RATE;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(REPEAT_DLY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

    rep_state_t       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       held, held_next;
    logic             valid;

    assign valid  = is_one_hot(btns);
    assign moving = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            held  <= BTN_NONE;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            held  <= held_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        held_next  = held;
        move       = 1'b0;
        dir        = btns;
        case (state)
            IDLE: begin
                if (valid) begin
                    move       = 1'b1;
                    state_next = PRESS;
                    cnt_next   = '0;
                    held_next  = btns;
                end
            end
            PRESS, REPEAT: begin
                if (!valid) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    held_next  = BTN_NONE;
                end else if (btns != held) begin
                    // A different button restarts the whole delay sequence.
                    move       = 1'b1;
                    state_next = PRESS;
                    cnt_next   = '0;
                    held_next  = btns;
                end else if ((state == PRESS  && cnt == DLY_LAST) ||
                             (state == REPEAT && cnt == RATE_LAST)) begin
                    move       = 1'b1;
                    state_next = REPEAT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
                held_next  = BTN_NONE;
            end
        endcase
    end

endmodule

// File: rtl/movable_block.sv
// Button-driven rectangle with edge wrap/clamp and registered collision
// flags telling the player which directions this block forbids.
module movable_block
    import movable_block_pkg::*;
#(
    parameter int COORD_W     = 11,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int OBJ_W       = 32,
    parameter int OBJ_H       = 32,
    parameter int P_SIZE      = 12,
    parameter int STEP        = 1,
    parameter int WRAP        = 1,
    parameter int REPEAT_DLY  = 20,
    parameter int REPEAT_RATE = 4
) (
    input  logic            btnClk,
    input  logic            rst,
    movable_block_if.slave  bus
);
    typedef logic [COORD_W:0] ext_t;

    localparam ext_t STEP_X = ext_t'(STEP);
    localparam ext_t H_MAX  = ext_t'(edge_max(H_RES, OBJ_W));
    localparam ext_t V_MAX  = ext_t'(edge_max(V_RES, OBJ_H));
    localparam ext_t H_MIN  = ext_t'(EDGE_MIN);
    localparam ext_t V_MIN  = ext_t'(EDGE_MIN);
    localparam ext_t W_X    = ext_t'(OBJ_W);
    localparam ext_t H_X    = ext_t'(OBJ_H);
    localparam ext_t P_X    = ext_t'(P_SIZE);

    logic               move;
    logic [3:0]         dir;
    logic [COORD_W-1:0] h_pos, v_pos;
    ext_t               h_ext, v_ext, h_next, v_next, ph, pv;
    logic               qualify, h_ov, v_ov, overlap_now, overlap_prev;
    logic               up_c, down_c, left_c, right_c;
    logic               up_r, down_r, left_r, right_r, hit_r;

    btn_repeat #(
        .REPEAT_DLY  (REPEAT_DLY),
        .REPEAT_RATE (REPEAT_RATE)
    ) u_repeat (
        .clk    (btnClk),
        .rst    (rst),
        .btns   (bus.btns),
        .move   (move),
        .dir    (dir),
        .moving (bus.moving)
    );

    assign h_ext = {1'b0, h_pos};
    assign v_ext = {1'b0, v_pos};

    // One-bit-wider arithmetic so edge tests never see a wrapped sum.
    always_comb begin
        h_next = h_ext;
        v_next = v_ext;
        if (move) begin
            case (dir)
                BTN_U: v_next = (v_ext >= STEP_X) ? v_ext - STEP_X
                                                  : ((WRAP != 0) ? V_MAX : V_MIN);
                BTN_D: v_next = (v_ext + STEP_X <= V_MAX) ? v_ext + STEP_X
                                                          : ((WRAP != 0) ? V_MIN : V_MAX);
                BTN_L: h_next = (h_ext >= STEP_X) ? h_ext - STEP_X
                                                  : ((WRAP != 0) ? H_MAX : H_MIN);
                BTN_R: h_next = (h_ext + STEP_X <= H_MAX) ? h_ext + STEP_X
                                                          : ((WRAP != 0) ? H_MIN : H_MAX);
                default: ;
            endcase
        end
    end

    always_ff @(posedge btnClk or negedge rst) begin
        if (!rst) begin
            h_pos <= bus.hStart;
            v_pos <= bus.vStart;
        end else begin
            h_pos <= h_next[COORD_W-1:0];
            v_pos <= v_next[COORD_W-1:0];
        end
    end

    assign ph      = {1'b0, bus.player_hPos};
    assign pv      = {1'b0, bus.player_vPos};
    assign qualify = bus.visible && !bus.passable && (bus.rect_color != bus.player_color);

    always_comb begin
        h_ov        = (ph < h_ext + W_X) && (ph + P_X > h_ext);
        v_ov        = (pv < v_ext + H_X) && (pv + P_X > v_ext);
        down_c      = qualify && h_ov && (pv + P_X == v_ext);
        up_c        = qualify && h_ov && (pv == v_ext + H_X);
        right_c     = qualify && v_ov && (ph + P_X == h_ext);
        left_c      = qualify && v_ov && (ph == h_ext + W_X);
        overlap_now = qualify && h_ov && v_ov;
    end

    // Flags follow the current position every cycle; hit fires on overlap entry only.
    always_ff @(posedge btnClk or negedge rst) begin
        if (!rst) begin
            up_r         <= 1'b0;
            down_r       <= 1'b0;
            left_r       <= 1'b0;
            right_r      <= 1'b0;
            hit_r        <= 1'b0;
            overlap_prev <= 1'b0;
        end else begin
            up_r         <= up_c;
            down_r       <= down_c;
            left_r       <= left_c;
            right_r      <= right_c;
            hit_r        <= overlap_now && !overlap_prev;
            overlap_prev <= overlap_now;
        end
    end

    assign bus.hPos       = h_pos;
    assign bus.vPos       = v_pos;
    assign bus.upBlock    = up_r;
    assign bus.downBlock  = down_r;
    assign bus.leftBlock  = left_r;
    assign bus.rightBlock = right_r;
    assign bus.hit        = hit_r;

endmodule

// File: tb/tb_movable_block.sv
// Scoreboard bench for movable_block: one wrapping and one clamping instance
// share clock, reset and stimulus; expectations are queued as stimulus is driven.
module tb_movable_block;
    import movable_block_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] value;
    } exp_t;

    logic btnClk = 1'b0;
    logic rst    = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;
    exp_t sb[$];

    movable_block_if #(.COORD_W(11)) bus1 ();
    movable_block_if #(.COORD_W(11)) bus0 ();

    movable_block #(.WRAP(1)) dut1 (.btnClk(btnClk), .rst(rst), .bus(bus1));
    movable_block #(.WRAP(0)) dut0 (.btnClk(btnClk), .rst(rst), .bus(bus0));

    always #5 btnClk = ~btnClk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge btnClk);
        #1;
    endtask

    task automatic push_exp(input string name, input logic [31:0] value);
        exp_t e;
        e.name  = name;
        e.value = value;
        sb.push_back(e);
    endtask

    function automatic exp_t pop_exp();
        exp_t e;
        if (sb.size() == 0) begin
            e.name  = "empty_scoreboard";
            e.value = 'x;
        end else begin
            e = sb.pop_front();
        end
        return e;
    endfunction

    function automatic logic [31:0] flags1();
        return {28'd0, bus1.upBlock, bus1.downBlock, bus1.leftBlock, bus1.rightBlock};
    endfunction

    task automatic set_btns(input logic [3:0] b);
        bus1.btns = b;
        bus0.btns = b;
    endtask

    task automatic set_player(input int h, input int v);
        bus1.player_hPos = 11'(h);
        bus1.player_vPos = 11'(v);
        bus0.player_hPos = 11'(h);
        bus0.player_vPos = 11'(v);
    endtask

    task automatic apply_reset(input int h, input int v);
        rst = 1'b0;
        bus1.hStart = 11'(h);
        bus1.vStart = 11'(v);
        bus0.hStart = 11'(h);
        bus0.vStart = 11'(v);
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e;
        set_btns(BTN_NONE);
        bus1.visible = 1'b0; bus0.visible = 1'b0;
        bus1.passable = 1'b0; bus0.passable = 1'b0;
        bus1.rect_color = 4'd3; bus0.rect_color = 4'd3;
        bus1.player_color = 4'd5; bus0.player_color = 4'd5;
        set_player(0, 0);
        bus1.hStart = 11'd100; bus1.vStart = 11'd50;
        bus0.hStart = 11'd100; bus0.vStart = 11'd50;
        rst = 1'b0;
        push_exp("reset_hPos", 100);
        push_exp("reset_vPos", 50);
        push_exp("reset_moving", 0);
        push_exp("reset_hit", 0);
        push_exp("reset_flags", 0);
        tick();
        tick();
        e = pop_exp(); compared++;
        if (32'(bus1.hPos) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.hPos, e.value); end
        e = pop_exp(); compared++;
        if (32'(bus1.vPos) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.vPos, e.value); end
        e = pop_exp(); compared++;
        if (32'(bus1.moving) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.moving, e.value); end
        e = pop_exp(); compared++;
        if (32'(bus1.hit) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.hit, e.value); end
        e = pop_exp(); compared++;
        if (flags1() !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, flags1(), e.value); end
        rst = 1'b1;
    endtask

    // Moves land at cycles 0, 20, 24 and 28 of the hold.
    task automatic test_hold_repeat();
        exp_t e;
        int moves;
        apply_reset(100, 50);
        set_btns(BTN_R);
        for (int k = 0; k < 30; k++) begin
            moves = 1 + ((k >= 20) ? 1 : 0) + ((k >= 24) ? 1 : 0) + ((k >= 28) ? 1 : 0);
            push_exp($sformatf("hold_hPos_c%0d", k), 32'(100 + moves));
            tick();
            e = pop_exp(); compared++;
            if (32'(bus1.hPos) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.hPos, e.value); end
        end
        push_exp("hold_moving", 1);
        e = pop_exp(); compared++;
        if (32'(bus1.moving) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.moving, e.value); end
        set_btns(BTN_NONE);
        push_exp("release_moving", 0);
        push_exp("release_hPos", 104);
        push_exp("release_vPos", 50);
        tick();
        e = pop_exp(); compared++;
        if (32'(bus1.moving) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.moving, e.value); end
        e = pop_exp(); compared++;
        if (32'(bus1.hPos) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.hPos, e.value); end
        e = pop_exp(); compared++;
        if (32'(bus1.vPos) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.vPos, e.value); end
    endtask

    task automatic test_direction_change();
        exp_t e;
        set_btns(BTN_R);
        push_exp("chg_first_hPos", 105);
        tick();
        e = pop_exp(); compared++;
        if (32'(bus1.hPos) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.hPos, e.value); end
        set_btns(BTN_D);
        push_exp("chg_new_vPos", 51);
        push_exp("chg_keep_hPos", 105);
        tick();
        e = pop_exp(); compared++;
        if (32'(bus1.vPos) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.vPos, e.value); end
        e = pop_exp(); compared++;
        if (32'(bus1.hPos) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.hPos, e.value); end
        // Re-entered PRESS: the next move is a full delay away.
        for (int k = 1; k < 20; k++) tick();
        push_exp("chg_delay_vPos", 51);
        e = pop_exp(); compared++;
        if (32'(bus1.vPos) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.vPos, e.value); end
        push_exp("chg_repeat_vPos", 52);
        tick();
        e = pop_exp(); compared++;
        if (32'(bus1.vPos) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.vPos, e.value); end
        set_btns(BTN_NONE);
        tick();
    endtask

    task automatic press_once(input logic [3:0] b, input string tag,
                              input int exp_h1, input int exp_v1,
                              input int exp_h0, input int exp_v0);
        exp_t e;
        set_btns(b);
        push_exp({tag, "_wrap_hPos"}, 32'(exp_h1));
        push_exp({tag, "_wrap_vPos"}, 32'(exp_v1));
        push_exp({tag, "_clamp_hPos"}, 32'(exp_h0));
        push_exp({tag, "_clamp_vPos"}, 32'(exp_v0));
        tick();
        set_btns(BTN_NONE);
        e = pop_exp(); compared++;
        if (32'(bus1.hPos) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.hPos, e.value); end
        e = pop_exp(); compared++;
        if (32'(bus1.vPos) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.vPos, e.value); end
        e = pop_exp(); compared++;
        if (32'(bus0.hPos) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus0.hPos, e.value); end
        e = pop_exp(); compared++;
        if (32'(bus0.vPos) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus0.vPos, e.value); end
        tick();
    endtask

    task automatic test_edges();
        apply_reset(0, 0);
        press_once(BTN_U, "up_edge",    0,   448, 0, 0);
        press_once(BTN_D, "down_edge",  0,   0,   0, 1);
        press_once(BTN_L, "left_edge",  608, 0,   0, 1);
        press_once(BTN_R, "right_edge", 0,   0,   1, 1);
        apply_reset(608, 448);
        press_once(BTN_D, "down_max",   608, 0,   608, 448);
        press_once(BTN_R, "right_max",  0,   0,   608, 448);
    endtask

    task automatic test_invalid();
        exp_t e;
        logic [3:0] pats [3];
        pats[0] = 4'b1010; pats[1] = 4'b1111; pats[2] = 4'b0110;
        apply_reset(100, 50);
        for (int p = 0; p < 3; p++) begin
            set_btns(pats[p]);
            for (int k = 0; k < 50; k++) begin
                tick();
                if (k % 10 == 9) begin
                    push_exp($sformatf("invalid%0d_hPos_c%0d", p, k), 100);
                    push_exp($sformatf("invalid%0d_vPos_c%0d", p, k), 50);
                    push_exp($sformatf("invalid%0d_moving_c%0d", p, k), 0);
                    e = pop_exp(); compared++;
                    if (32'(bus1.hPos) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.hPos, e.value); end
                    e = pop_exp(); compared++;
                    if (32'(bus1.vPos) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.vPos, e.value); end
                    e = pop_exp(); compared++;
                    if (32'(bus1.moving) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.moving, e.value); end
                end
            end
        end
        set_btns(BTN_NONE);
        tick();
    endtask

    // Flag vector order is {up, down, left, right}.
    task automatic test_collision();
        exp_t e;
        int ph [7];
        int pv [7];
        logic [3:0] pcol [7];
        logic pass [7];
        logic vis [7];
        logic [3:0] want [7];
        ph = '{110, 110, 110, 110, 110, 88, 132};
        pv = '{88, 88, 88, 88, 132, 110, 110};
        pcol = '{4'd5, 4'd3, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
        pass = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vis  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        want = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001, 4'b0010};
        apply_reset(100, 100);
        bus1.rect_color = 4'd3;
        for (int i = 0; i < 7; i++) begin
            set_player(ph[i], pv[i]);
            bus1.player_color = pcol[i];
            bus1.passable = pass[i];
            bus1.visible = vis[i];
            push_exp($sformatf("flags_case%0d", i), {28'd0, want[i]});
            tick();
            e = pop_exp(); compared++;
            if (flags1() !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %b, required %b", e.name, flags1(), e.value); end
        end
    endtask

    task automatic test_hit();
        exp_t e;
        int hv [6];
        int vv [6];
        logic [3:0] pcol [6];
        logic want [6];
        hv = '{100, 110, 110, 110, 100, 110};
        vv = '{60, 110, 110, 110, 60, 110};
        pcol = '{4'd5, 4'd5, 4'd5, 4'd5, 4'd3, 4'd3};
        want = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        bus1.visible = 1'b1;
        bus1.passable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_player(hv[i], vv[i]);
            bus1.player_color = pcol[i];
            push_exp($sformatf("hit_step%0d", i), {31'd0, want[i]});
            tick();
            e = pop_exp(); compared++;
            if (32'(bus1.hit) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.hit, e.value); end
        end
        bus1.player_color = 4'd5;
        bus1.visible = 1'b0;
    endtask

    task automatic test_reset_mid_repeat();
        exp_t e;
        apply_reset(100, 50);
        set_btns(BTN_R);
        for (int k = 0; k < 25; k++) tick();
        push_exp("midrep_hPos", 103);
        push_exp("midrep_moving", 1);
        push_exp("abort_hPos", 100);
        push_exp("abort_moving", 0);
        push_exp("repress_hPos", 101);
        push_exp("repress_moving", 1);
        e = pop_exp(); compared++;
        if (32'(bus1.hPos) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.hPos, e.value); end
        e = pop_exp(); compared++;
        if (32'(bus1.moving) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.moving, e.value); end
        rst = 1'b0;
        #2;
        e = pop_exp(); compared++;
        if (32'(bus1.hPos) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.hPos, e.value); end
        e = pop_exp(); compared++;
        if (32'(bus1.moving) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.moving, e.value); end
        tick();
        rst = 1'b1;
        tick();
        e = pop_exp(); compared++;
        if (32'(bus1.hPos) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.hPos, e.value); end
        e = pop_exp(); compared++;
        if (32'(bus1.moving) !== e.value) begin mismatched++; $display("[TB] FAIL %s: got %0d, required %0d", e.name, bus1.moving, e.value); end
        set_btns(BTN_NONE);
        tick();
    endtask

    initial begin
        test_reset();
        test_hold_repeat();
        test_direction_change();
        test_edges();
        test_invalid();
        test_collision();
        test_hit();
        test_reset_mid_repeat();
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
